// File: rtl/sokoban_pkg.sv
// rtl/sokoban_pkg.sv - shared direction codes, queue FSM states and direction priority
package sokoban_pkg;

  // 2-bit move command codes as seen by the game core
  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  // Issue FSM states of the move command queue
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PRESENT = 2'b01,
    HOLDOFF = 2'b10
  } mvq_state_e;

  // Result of resolving one cycle of action pulses
  typedef struct packed {
    logic valid;  // at least one pulse present
    logic multi;  // more than one pulse: the losers are discarded
    dir_e code;   // winning direction
  } dir_pick_t;

  // Same-cycle pulses resolve as up > down > left > right
  function automatic dir_pick_t pick_dir(input logic up, input logic down,
                                         input logic left, input logic right);
    dir_pick_t p;
    p.valid = up | down | left | right;
    p.multi = (up & (down | left | right)) | (down & (left | right)) | (left & right);
    if (up)        p.code = DIR_UP;
    else if (down) p.code = DIR_DOWN;
    else if (left) p.code = DIR_LEFT;
    else           p.code = DIR_RIGHT;
    return p;
  endfunction

endpackage

// File: rtl/mvq_fifo.sv
// rtl/mvq_fifo.sv - synchronous FIFO with flush, level and full/empty flags
module mvq_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  data_i,
  output logic [W-1:0]  data_o,
  output logic [LW-1:0] level_o,
  output logic [LW-1:0] level_next_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          wr_en, rd_en;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);

  // A write into a full FIFO is only legal when the head leaves in the same cycle
  assign rd_en = pop_i & ~empty_o & ~flush_i;
  assign wr_en = push_i & (~full_o | rd_en) & ~flush_i;

  // Pointer and level next-state; pointers wrap naturally at DEPTH (power of two)
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Pointer, level and storage registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      if (wr_en) mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign data_o       = mem_q[rd_ptr_q];
  assign level_o      = level_q;
  assign level_next_o = level_d;

endmodule

// File: rtl/move_cmd_queue.sv
// rtl/move_cmd_queue.sv - direction pulse encoder, move FIFO and paced valid/ready issue
module move_cmd_queue
  import sokoban_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 16,
  parameter int DROP_W     = 8
) (
  input  logic                    MVQ_clk,
  input  logic                    MVQ_rst,
  input  logic                    MVQ_flush,
  input  logic                    MVQ_up,
  input  logic                    MVQ_down,
  input  logic                    MVQ_left,
  input  logic                    MVQ_right,
  output logic                    MVQ_dir_valid,
  output logic [1:0]              MVQ_dir_code,
  input  logic                    MVQ_dir_ready,
  output logic [$clog2(DEPTH):0]  MVQ_level,
  output logic                    MVQ_overflow,
  output logic [DROP_W-1:0]       MVQ_drop_cnt
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int CW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  dir_pick_t         pick;
  logic              pop_req, push_ok, lost, drop_evt;
  logic              fifo_full, fifo_empty;
  logic [LW-1:0]     level_nx;
  logic [1:0]        head;
  mvq_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              overflow_q;
  logic [DROP_W-1:0] drop_q;

  assign pick = pick_dir(MVQ_up, MVQ_down, MVQ_left, MVQ_right);

  // Flush wins over everything in its cycle: no push, no pop, nothing counted
  assign pop_req  = MVQ_dir_valid & MVQ_dir_ready & ~MVQ_flush;
  assign push_ok  = pick.valid & (~fifo_full | pop_req) & ~MVQ_flush;
  assign lost     = pick.valid & fifo_full & ~pop_req & ~MVQ_flush;
  assign drop_evt = (pick.multi | lost) & ~MVQ_flush;

  mvq_fifo #(
    .DEPTH (DEPTH),
    .W     (2)
  ) u_fifo (
    .clk_i        (MVQ_clk),
    .rst_i        (MVQ_rst),
    .flush_i      (MVQ_flush),
    .push_i       (push_ok),
    .pop_i        (pop_req),
    .data_i       (pick.code),
    .data_o       (head),
    .level_o      (MVQ_level),
    .level_next_o (level_nx),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty)
  );

  // State register and hold-off counter
  always_ff @(posedge MVQ_clk) begin
    if (MVQ_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: decisions use the post-update level so a push reaches the core next cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (MVQ_flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (level_nx != '0) state_d = PRESENT;
        end
        PRESENT: begin
          if (pop_req) begin
            if (GAP_CYCLES > 0) begin
              state_d = HOLDOFF;
              cnt_d   = CW'(GAP_CYCLES);
            end else if (level_nx != '0) begin
              state_d = PRESENT;
            end else begin
              state_d = IDLE;
            end
          end
        end
        HOLDOFF: begin
          if (cnt_q <= CW'(1)) begin
            cnt_d   = '0;
            state_d = (level_nx != '0) ? PRESENT : IDLE;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs: the head is only offered while presenting; the code always mirrors the head
  always_comb begin
    MVQ_dir_valid = (state_q == PRESENT) && !fifo_empty;
    MVQ_dir_code  = head;
  end

  // Sticky overflow flag and saturating drop counter, cleared only by reset
  always_ff @(posedge MVQ_clk) begin
    if (MVQ_rst) begin
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      if (lost) overflow_q <= 1'b1;
      if (drop_evt && (drop_q != '1)) drop_q <= drop_q + DROP_W'(1);
    end
  end

  assign MVQ_overflow = overflow_q;
  assign MVQ_drop_cnt = drop_q;

endmodule

// File: tb/tb_move_cmd_queue.sv
// tb/tb_move_cmd_queue.sv - self-checking bench for move_cmd_queue
module tb_move_cmd_queue;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
  logic       ready1 = 1'b0, ready0 = 1'b0;

  logic       v1, v0;
  logic [1:0] c1, c0;
  logic [2:0] l1, l0;
  logic       o1, o0;
  logic [7:0] d1, d0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] q1[$];
  logic [1:0] q0[$];
  logic       mon1_en = 1'b0, mon0_en = 1'b0;

  always #20 clk = ~clk;

  move_cmd_queue #(.DEPTH(4), .GAP_CYCLES(16), .DROP_W(8)) u_dut (
    .MVQ_clk(clk), .MVQ_rst(rst), .MVQ_flush(flush),
    .MVQ_up(up), .MVQ_down(down), .MVQ_left(left), .MVQ_right(right),
    .MVQ_dir_valid(v1), .MVQ_dir_code(c1), .MVQ_dir_ready(ready1),
    .MVQ_level(l1), .MVQ_overflow(o1), .MVQ_drop_cnt(d1)
  );

  move_cmd_queue #(.DEPTH(4), .GAP_CYCLES(0), .DROP_W(8)) u_dut0 (
    .MVQ_clk(clk), .MVQ_rst(rst), .MVQ_flush(flush),
    .MVQ_up(up), .MVQ_down(down), .MVQ_left(left), .MVQ_right(right),
    .MVQ_dir_valid(v0), .MVQ_dir_code(c0), .MVQ_dir_ready(ready0),
    .MVQ_level(l0), .MVQ_overflow(o0), .MVQ_drop_cnt(d0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    {up, down, left, right} = 4'b0;
    flush = 1'b0;
    cyc();
    rst = 1'b0;
    q1.delete();
    q0.delete();
  endtask

  // Scoreboard: every handshake pops the oldest expected command
  always @(negedge clk) begin
    if (mon1_en && v1 && ready1) begin
      if (q1.size() == 0) chk("hs1_unexpected", 1, 0);
      else chk("hs1_code", c1, q1.pop_front());
    end
    if (mon0_en && v0 && ready0) begin
      if (q0.size() == 0) chk("hs0_unexpected", 1, 0);
      else chk("hs0_code", c0, q0.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       rst;
    logic [3:0] pulses;  // {up, down, left, right}
    logic       exp_valid;
    logic [2:0] exp_level;
    logic [1:0] exp_code;
    logic [7:0] exp_drop;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int low_cnt;

    vecs[0] = '{1'b1, 4'b0000, 1'b0, 3'd0, 2'b00, 8'd0, 1'b0};
    vecs[1] = '{1'b0, 4'b1001, 1'b1, 3'd1, 2'b00, 8'd1, 1'b0};
    vecs[2] = '{1'b1, 4'b0000, 1'b0, 3'd0, 2'b00, 8'd0, 1'b0};
    vecs[3] = '{1'b0, 4'b0100, 1'b1, 3'd1, 2'b01, 8'd0, 1'b0};
    vecs[4] = '{1'b0, 4'b0010, 1'b1, 3'd2, 2'b01, 8'd0, 1'b0};
    vecs[5] = '{1'b0, 4'b0001, 1'b1, 3'd3, 2'b01, 8'd0, 1'b0};
    vecs[6] = '{1'b0, 4'b1000, 1'b1, 3'd4, 2'b01, 8'd0, 1'b0};
    vecs[7] = '{1'b0, 4'b0100, 1'b1, 3'd4, 2'b01, 8'd1, 1'b1};

    cyc();
    cyc();
    rst = 1'b0;

    // Table: reset state, simultaneous pulses, fill to full and overflow (ready low)
    for (int i = 0; i < 8; i++) begin
      rst = vecs[i].rst;
      {up, down, left, right} = vecs[i].pulses;
      cyc();
      {up, down, left, right} = 4'b0;
      chk($sformatf("vec%0d_valid", i), v1, vecs[i].exp_valid);
      chk($sformatf("vec%0d_level", i), l1, vecs[i].exp_level);
      chk($sformatf("vec%0d_code", i),  c1, vecs[i].exp_code);
      chk($sformatf("vec%0d_drop", i),  d1, vecs[i].exp_drop);
      chk($sformatf("vec%0d_ovf", i),   o1, vecs[i].exp_ovf);
    end
    rst = 1'b0;

    // Single left pulse, immediate handshake, then exactly 16 idle cycles of hold-off
    do_reset();
    mon1_en = 1'b1;
    repeat (8) cyc();
    left = 1'b1; ready1 = 1'b1; q1.push_back(2'b10);
    cyc();
    left = 1'b0;
    chk("t1_valid_rise", v1, 1);
    chk("t1_code", c1, 2'b10);
    chk("t1_level1", l1, 1);
    cyc();
    chk("t1_level_after_hs", l1, 0);
    low_cnt = (v1 == 1'b0) ? 1 : 0;
    up = 1'b1; q1.push_back(2'b00);
    cyc();
    up = 1'b0;
    for (int k = 0; k < 15; k++) begin
      if (v1 == 1'b0) low_cnt++;
      cyc();
    end
    chk("t1_gap_low_cycles", low_cnt, 16);
    chk("t1_valid_after_gap", v1, 1);
    chk("t1_code2", c1, 2'b00);
    cyc();
    chk("t1_level_end", l1, 0);
    repeat (20) cyc();
    chk("t1_valid_end", v1, 0);
    chk("t1_sb_empty", q1.size(), 0);
    mon1_en = 1'b0; ready1 = 1'b0;

    // Full queue, GAP 0: simultaneous pop and push, then drain in order
    do_reset();
    mon0_en = 1'b1;
    down = 1'b1; q0.push_back(2'b01); cyc(); down = 1'b0;
    left = 1'b1; q0.push_back(2'b10); cyc(); left = 1'b0;
    right = 1'b1; q0.push_back(2'b11); cyc(); right = 1'b0;
    up = 1'b1; q0.push_back(2'b00); cyc(); up = 1'b0;
    chk("t4_full_level", l0, 4);
    up = 1'b1; ready0 = 1'b1; q0.push_back(2'b00);
    cyc();
    up = 1'b0;
    chk("t4_level_pp", l0, 4);
    chk("t4_ovf", o0, 0);
    chk("t4_drop", d0, 0);
    for (int k = 3; k >= 0; k--) begin
      cyc();
      chk($sformatf("t4_drain_level%0d", k), l0, k);
    end
    chk("t4_valid_end", v0, 0);
    chk("t4_sb_empty", q0.size(), 0);
    mon0_en = 1'b0; ready0 = 1'b0;

    // Flush with a same-cycle push at level 3 keeps the statistics
    do_reset();
    up = 1'b1; down = 1'b1; cyc(); up = 1'b0; down = 1'b0;
    down = 1'b1; cyc(); down = 1'b0;
    left = 1'b1; cyc(); left = 1'b0;
    chk("t5_level3", l1, 3);
    flush = 1'b1; right = 1'b1;
    cyc();
    flush = 1'b0; right = 1'b0;
    chk("t5_level", l1, 0);
    chk("t5_valid", v1, 0);
    chk("t5_drop", d1, 1);
    chk("t5_ovf", o1, 0);
    right = 1'b1; cyc(); right = 1'b0;
    chk("t5_repush_level", l1, 1);
    chk("t5_repush_code", c1, 2'b11);

    // Drop counter saturation, then reset overriding live pulses, flush and ready
    do_reset();
    up = 1'b1; down = 1'b1;
    repeat (300) cyc();
    chk("t6_drop_sat", d1, 255);
    chk("t6_ovf", o1, 1);
    chk("t6_level", l1, 4);
    rst = 1'b1; flush = 1'b1; ready1 = 1'b1;
    cyc();
    chk("t6_rst_valid", v1, 0);
    chk("t6_rst_code", c1, 0);
    chk("t6_rst_level", l1, 0);
    chk("t6_rst_ovf", o1, 0);
    chk("t6_rst_drop", d1, 0);
    rst = 1'b0; flush = 1'b0; ready1 = 1'b0;
    up = 1'b0; down = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
